// File: rtl/aftab_multiplier_seq.sv
// Sequential unsigned shift-add multiplier for the AFTAB AAU.
// Multiplies two size-bit operands into a 2*size-bit product, one
// add/shift step per clock, with a start/done handshake to the AAU controller.
//
// Ports:
//   clk          : system clock, rising edge
//   rst          : synchronous active-low reset
//   startMult    : start request, honoured only while idle
//   multiplicand : operand M, captured on the accepting edge
//   multiplier   : operand Q, captured on the accepting edge
//   product      : result register, holds the last result until the next completion
//   doneMult     : one-cycle completion pulse (high while in DONE)
//   busy         : high from the accepting edge until DONE is left
module aftab_multiplier_seq #(
  parameter int unsigned size = 33
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                startMult,
  input  logic [size-1:0]     multiplicand,
  input  logic [size-1:0]     multiplier,
  output logic [2*size-1:0]   product,
  output logic                doneMult,
  output logic                busy
);

  localparam int unsigned CntW = $clog2(size + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e          state_q;
  logic [size-1:0] m_q;
  logic [size-1:0] a_q;
  logic [size-1:0] q_q;
  logic [CntW-1:0] cnt_q;
  logic [size:0]   sum_d;

  // Partial-product add; sum_d[size] is the carry, which lands in A's MSB
  // on the following right shift, so no separate carry flop is needed.
  assign sum_d = {1'b0, a_q} + (q_q[0] ? {1'b0, m_q} : '0);

  // Controller and datapath; doneMult/busy track the state they decode from.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      m_q      <= '0;
      a_q      <= '0;
      q_q      <= '0;
      cnt_q    <= '0;
      product  <= '0;
      doneMult <= 1'b0;
      busy     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (startMult) begin
            m_q     <= multiplicand;
            q_q     <= multiplier;
            a_q     <= '0;
            cnt_q   <= CntW'(size);
            busy    <= 1'b1;
            state_q <= MULT;
          end
        end
        MULT: begin
          a_q   <= sum_d[size:1];
          q_q   <= {sum_d[0], q_q[size-1:1]};
          cnt_q <= cnt_q - CntW'(1);
          // Last of the size iterations: next cycle is the DONE pulse.
          if (cnt_q == CntW'(1)) begin
            state_q  <= DONE;
            doneMult <= 1'b1;
          end
        end
        DONE: begin
          product  <= {a_q, q_q};
          doneMult <= 1'b0;
          busy     <= 1'b0;
          state_q  <= IDLE;
        end
        default: begin
          doneMult <= 1'b0;
          busy     <= 1'b0;
          state_q  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aftab_multiplier_seq.sv
// Self-checking bench for aftab_multiplier_seq: table of fixed and random
// operand pairs against plain-arithmetic products, plus handshake sequences
// (ignored start, mid-operation reset, back-to-back starts).
module tb_aftab_multiplier_seq;

  localparam int unsigned SIZE = 33;
  localparam int unsigned PW   = 2 * SIZE;
  localparam int          BUDGET = 200;

  logic            clk;
  logic            rst;
  logic            startMult;
  logic [SIZE-1:0] multiplicand;
  logic [SIZE-1:0] multiplier;
  logic [PW-1:0]   product;
  logic            doneMult;
  logic            busy;

  int vectors;
  int miscompares;
  logic [PW-1:0] prev_product;

  typedef struct {
    logic [SIZE-1:0] a;
    logic [SIZE-1:0] b;
    logic [PW-1:0]   exp;
  } vec_t;

  vec_t vecs[10];

  aftab_multiplier_seq #(.size(SIZE)) dut (
    .clk          (clk),
    .rst          (rst),
    .startMult    (startMult),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .product      (product),
    .doneMult     (doneMult),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: the exact unsigned product, no width loss in 2*SIZE bits.
  function automatic logic [PW-1:0] ref_mul(input logic [SIZE-1:0] a, input logic [SIZE-1:0] b);
    return PW'(a) * PW'(b);
  endfunction

  task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Present operands with startMult high; returns just after the accepting edge.
  task automatic accept(input logic [SIZE-1:0] a, input logic [SIZE-1:0] b);
    @(negedge clk);
    multiplicand = a;
    multiplier   = b;
    startMult    = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Follow one operation to completion. hold: 0 = drop start at once,
  // n > 0 = drop it at the n-th cycle, -1 = leave it high.
  task automatic finish(input logic [PW-1:0] exp, input int hold);
    int n;
    bit seen;
    if (hold == 0) startMult = 1'b0;
    seen = 1'b0;
    n = 0;
    while (!seen && n < BUDGET) begin
      @(negedge clk);
      n++;
      if (n == hold) startMult = 1'b0;
      if (n == 1) chk("busy_after_start", PW'(busy), PW'(1));
      if (doneMult) seen = 1'b1;
      else chk("product_held", product, prev_product);
    end
    if (!seen) begin
      chk("done_timeout", PW'(n), PW'(SIZE + 1));
    end else begin
      // Done pulse is visible in the cycle after the SIZE-th MULT edge.
      chk("done_latency", PW'(n), PW'(SIZE + 1));
      chk("busy_in_done", PW'(busy), PW'(1));
      chk("product_in_done", product, prev_product);
      @(negedge clk);
      chk("done_one_cycle", PW'(doneMult), PW'(0));
      chk("busy_after_done", PW'(busy), PW'(0));
      chk("product", product, exp);
    end
    prev_product = exp;
  endtask

  initial begin
    vectors      = 0;
    miscompares  = 0;
    prev_product = '0;
    rst          = 1'b0;
    startMult    = 1'b0;
    multiplicand = '0;
    multiplier   = '0;

    vecs[0] = '{a: 33'd5,           b: 33'd3,           exp: 66'd15};
    vecs[1] = '{a: 33'h1_FFFF_FFFF, b: 33'h1_FFFF_FFFF, exp: 66'h3_FFFF_FFFC_0000_0001};
    vecs[2] = '{a: 33'd0,           b: 33'h1_2345_6789, exp: 66'd0};
    vecs[3] = '{a: 33'd1,           b: 33'h1_2345_6789, exp: 66'h1_2345_6789};
    vecs[4] = '{a: 33'h1_0000_0000, b: 33'd2,           exp: 66'h2_0000_0000};
    for (int i = 5; i < 10; i++) begin
      logic [SIZE-1:0] ra;
      logic [SIZE-1:0] rb;
      ra[31:0] = $urandom;
      ra[32]   = 1'($urandom);
      rb[31:0] = $urandom;
      rb[32]   = 1'($urandom);
      vecs[i] = '{a: ra, b: rb, exp: ref_mul(ra, rb)};
    end

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_product", product, '0);
    chk("reset_busy", PW'(busy), PW'(0));
    chk("reset_done", PW'(doneMult), PW'(0));
    rst = 1'b1;
    @(negedge clk);
    chk("idle_busy", PW'(busy), PW'(0));

    // Table-driven operand pairs
    for (int i = 0; i < 10; i++) begin
      accept(vecs[i].a, vecs[i].b);
      finish(vecs[i].exp, 0);
    end

    // Start held high with changing operands while busy is ignored
    accept(33'd6, 33'd9);
    multiplicand = 33'd7;
    multiplier   = 33'd7;
    startMult    = 1'b1;
    finish(66'd54, 10);
    repeat (3) begin
      @(negedge clk);
      chk("no_second_done", PW'(doneMult), PW'(0));
      chk("stays_idle", PW'(busy), PW'(0));
    end
    accept(33'd7, 33'd7);
    finish(66'd49, 0);

    // Reset in the middle of an operation, with a start on the reset edge
    accept(33'd100, 33'd200);
    startMult = 1'b0;
    repeat (9) begin
      @(negedge clk);
      chk("no_done_before_abort", PW'(doneMult), PW'(0));
    end
    rst       = 1'b0;
    startMult = 1'b1;
    @(negedge clk);
    chk("abort_busy", PW'(busy), PW'(0));
    chk("abort_done", PW'(doneMult), PW'(0));
    chk("abort_product", product, '0);
    rst       = 1'b1;
    startMult = 1'b0;
    prev_product = '0;
    repeat (SIZE + 4) begin
      @(negedge clk);
      chk("aborted_op_silent", PW'(doneMult | busy), PW'(0));
    end
    accept(33'd2, 33'd3);
    finish(66'd6, 0);

    // Back-to-back: start never dropped, second op taken on the IDLE edge
    accept(33'd3, 33'd4);
    multiplicand = 33'd5;
    multiplier   = 33'd6;
    finish(66'd12, -1);
    finish(66'd30, 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
